ptw_mem_arbiter: RTL and testbench

Shares one read-only memory port between the instruction-side and data-side MMU page-table walkers. Each walker issues single-word PTE reads with a level-held request. The arbiter grants one walker at a time with round-robin fairness and drives the downstream valid/ready address channel. It returns the response to the owner, discards responses for walkers that withdrew (flush), and bounds response latency with a watchdog.

---
 rtl/ptw_mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_ptw_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_mem_arbiter.sv
// ptw_mem_arbiter: shares one read-only memory port between the IFU and LSU
// page-table walkers. Round-robin grant, valid/ready address channel,
// response steering to the owner, flush discard and a response watchdog.
module ptw_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic [31:0] i_rdata_o,
  output logic        i_rvalid_o,
  output logic        i_rerr_o,
  input  logic        d_req_i,
  input  logic [31:0] d_addr_i,
  output logic [31:0] d_rdata_o,
  output logic        d_rvalid_o,
  output logic        d_rerr_o,
  output logic        mem_arvalid_o,
  output logic [31:0] mem_araddr_o,
  input  logic        mem_arready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rerr_i,
  output logic        busy_o,
  output logic        owner_o
);

  // Watchdog is at least 8 bits wide and grows to hold TIMEOUT.
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;     // 0 = IFU, 1 = LSU
  logic [31:0]      addr_q, addr_d;
  logic             abort_q, abort_d;     // owner withdrew during ADDR/WAIT
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rerr_q, rerr_d;
  logic             tmo_q, tmo_d;         // RESP was entered via timeout

  logic owner_req;
  logic abort_now;
  logic timeout_hit;
  logic grant_lsu;

  // The owner dropping its request in this very cycle counts as an abort, so a
  // simultaneous drop and response is discarded.
  assign owner_req   = owner_q ? d_req_i : i_req_i;
  assign abort_now   = abort_q | ~owner_req;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q >= TIMEOUT_C);
  // On a tie the walker that did not own the port last time wins.
  assign grant_lsu   = (i_req_i && d_req_i) ? ~owner_q : d_req_i;

  // Next-state and datapath decisions for the arbitration FSM.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    abort_d = abort_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    tmo_d   = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (i_req_i || d_req_i) begin
          owner_d = grant_lsu;
          addr_d  = grant_lsu ? d_addr_i : i_addr_i;
          abort_d = 1'b0;
          tmo_d   = 1'b0;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        // Valid is never withdrawn once raised; a drop only marks the abort.
        abort_d = abort_now;
        if (mem_arready_i) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        abort_d = abort_now;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (mem_rvalid_i) begin
          if (abort_now) begin
            state_d = S_IDLE;
          end else begin
            rdata_d = mem_rdata_i;
            rerr_d  = mem_rerr_i;
            state_d = S_RESP;
          end
        end else if (timeout_hit) begin
          if (abort_now) begin
            state_d = S_DRAIN;
          end else begin
            rdata_d = '0;
            rerr_d  = 1'b1;
            tmo_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end

      S_RESP: begin
        state_d = tmo_q ? S_DRAIN : S_IDLE;
      end

      S_DRAIN: begin
        // The late response of a timed-out read must not reach a new owner.
        if (mem_rvalid_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; owner resets to LSU so the first tie goes to the IFU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b1;
      addr_q  <= '0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign mem_arvalid_o = (state_q == S_ADDR);
  assign mem_araddr_o  = addr_q;
  assign busy_o        = (state_q != S_IDLE);
  assign owner_o       = owner_q;

  assign i_rvalid_o = (state_q == S_RESP) && !owner_q;
  assign d_rvalid_o = (state_q == S_RESP) &&  owner_q;
  assign i_rdata_o  = i_rvalid_o ? rdata_q : '0;
  assign d_rdata_o  = d_rvalid_o ? rdata_q : '0;
  assign i_rerr_o   = i_rvalid_o & rerr_q;
  assign d_rerr_o   = d_rvalid_o & rerr_q;

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// tb_ptw_mem_arbiter: directed stimulus with a scoreboard. Stimulus pushes the
// expected addresses and responses; a negedge monitor pops and compares.
module tb_ptw_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic [31:0] i_rdata_o;
  logic        i_rvalid_o;
  logic        i_rerr_o;
  logic        d_req_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_rdata_o;
  logic        d_rvalid_o;
  logic        d_rerr_o;
  logic        mem_arvalid_o;
  logic [31:0] mem_araddr_o;
  logic        mem_arready_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_rerr_i;
  logic        busy_o;
  logic        owner_o;

  ptw_mem_arbiter #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_i      (i_req_i),
    .i_addr_i     (i_addr_i),
    .i_rdata_o    (i_rdata_o),
    .i_rvalid_o   (i_rvalid_o),
    .i_rerr_o     (i_rerr_o),
    .d_req_i      (d_req_i),
    .d_addr_i     (d_addr_i),
    .d_rdata_o    (d_rdata_o),
    .d_rvalid_o   (d_rvalid_o),
    .d_rerr_o     (d_rerr_o),
    .mem_arvalid_o(mem_arvalid_o),
    .mem_araddr_o (mem_araddr_o),
    .mem_arready_i(mem_arready_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_rerr_i   (mem_rerr_i),
    .busy_o       (busy_o),
    .owner_o      (owner_o)
  );

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t       exp_resp[$];
  logic [31:0] exp_addr[$];
  resp_t       mon_r;
  int          n_checks = 0;
  int          n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_resp(input logic own, input logic [31:0] d, input logic e);
    resp_t r;
    r.owner = own;
    r.data  = d;
    r.err   = e;
    exp_resp.push_back(r);
  endtask

  // Plays the memory side of one read: waits for arvalid, stalls arready for
  // ar_wait cycles, then returns data r_wait cycles after WAIT entry.
  // Returns in the RESP cycle.
  task automatic mem_txn(input int ar_wait, input int r_wait,
                         input logic [31:0] data, input logic err);
    for (int k = 0; k < 20 && !mem_arvalid_o; k++) step();
    check("arvalid_seen", mem_arvalid_o, 1);
    repeat (ar_wait) step();
    mem_arready_i = 1'b1;
    step();
    mem_arready_i = 1'b0;
    repeat (r_wait) step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = data;
    mem_rerr_i   = err;
    step();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    mem_rerr_i   = 1'b0;
  endtask

  // Monitor: response steering, idle-zero outputs and address channel order.
  always @(negedge clk) begin
    if (!rst) begin
      if (i_rvalid_o || d_rvalid_o) begin
        if (exp_resp.size() == 0) begin
          check("unexpected_rvalid", {i_rvalid_o, d_rvalid_o}, 0);
        end else begin
          mon_r = exp_resp.pop_front();
          check("rvalid_owner", {i_rvalid_o, d_rvalid_o}, mon_r.owner ? 2'b01 : 2'b10);
          check("rdata", mon_r.owner ? d_rdata_o : i_rdata_o, mon_r.data);
          check("rerr", mon_r.owner ? d_rerr_o : i_rerr_o, mon_r.err);
        end
      end
      if (!i_rvalid_o) check("i_idle_zero", {i_rerr_o, i_rdata_o}, 0);
      if (!d_rvalid_o) check("d_idle_zero", {d_rerr_o, d_rdata_o}, 0);
      if (mem_arvalid_o) begin
        if (exp_addr.size() == 0) begin
          check("unexpected_arvalid", mem_arvalid_o, 0);
        end else begin
          check("araddr", mem_araddr_o, exp_addr[0]);
          if (mem_arready_i) void'(exp_addr.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    i_req_i = 1'b0; i_addr_i = '0;
    d_req_i = 1'b0; d_addr_i = '0;
    mem_arready_i = 1'b0; mem_rvalid_i = 1'b0;
    mem_rdata_i = '0; mem_rerr_i = 1'b0;
    #1;
    check("rst_owner", owner_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_arvalid", mem_arvalid_o, 0);
    check("rst_araddr", mem_araddr_o, 0);
    step(); step();
    rst = 1'b0;
    step();

    // IFU only, minimum latency.
    i_req_i = 1'b1; i_addr_i = 32'h8000_1000; mem_arready_i = 1'b1;
    exp_addr.push_back(32'h8000_1000);
    push_resp(1'b0, 32'h2000_0C01, 1'b0);
    step();
    check("t1_arvalid_c1", mem_arvalid_o, 1);
    check("t1_araddr_c1", mem_araddr_o, 32'h8000_1000);
    step();
    mem_arready_i = 1'b0;
    step(); step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h2000_0C01; mem_rerr_i = 1'b0;
    step();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; i_req_i = 1'b0;
    check("t1_i_rvalid", i_rvalid_o, 1);
    check("t1_i_rdata", i_rdata_o, 32'h2000_0C01);
    check("t1_d_rvalid", d_rvalid_o, 0);
    step();
    check("t1_pulse_end", i_rvalid_o, 0);
    check("t1_busy_idle", busy_o, 0);

    // Both requesting: alternation from a fresh reset starts with IFU.
    rst = 1'b1; step(); rst = 1'b0; step();
    i_req_i = 1'b1; i_addr_i = 32'h8000_A000;
    d_req_i = 1'b1; d_addr_i = 32'h8000_B000;
    exp_addr.push_back(32'h8000_A000); push_resp(1'b0, 32'h1111_0001, 1'b0);
    exp_addr.push_back(32'h8000_B000); push_resp(1'b1, 32'h2222_0002, 1'b0);
    exp_addr.push_back(32'h8000_A000); push_resp(1'b0, 32'h1111_0003, 1'b0);
    exp_addr.push_back(32'h8000_B000); push_resp(1'b1, 32'h2222_0004, 1'b0);
    mem_txn(0, 0, 32'h1111_0001, 1'b0);
    mem_txn(1, 1, 32'h2222_0002, 1'b0);
    mem_txn(0, 2, 32'h1111_0003, 1'b0);
    mem_txn(2, 3, 32'h2222_0004, 1'b0);
    i_req_i = 1'b0; d_req_i = 1'b0;
    step();

    // Address stall with IFU withdrawing: stable valid, response discarded.
    i_req_i = 1'b1; i_addr_i = 32'h8000_2000;
    exp_addr.push_back(32'h8000_2000);
    step();
    for (int k = 1; k <= 5; k++) begin
      check("t3_arvalid_held", mem_arvalid_o, 1);
      step();
      if (k == 1) i_req_i = 1'b0;
    end
    check("t3_arvalid_c6", mem_arvalid_o, 1);
    mem_arready_i = 1'b1;
    step();
    mem_arready_i = 1'b0;
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
    check("t3_busy_before", busy_o, 1);
    step();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    check("t3_busy_after", busy_o, 0);
    check("t3_no_i_rvalid", i_rvalid_o, 0);
    step();

    // Timeout on LSU, IFU pending through DRAIN.
    d_req_i = 1'b1; d_addr_i = 32'h8000_3000; mem_arready_i = 1'b1;
    exp_addr.push_back(32'h8000_3000);
    push_resp(1'b1, 32'h0, 1'b1);
    step();
    check("t4_grant_lsu", owner_o, 1);
    step();
    mem_arready_i = 1'b0;
    step();
    i_req_i = 1'b1; i_addr_i = 32'h8000_4000;
    step(); step(); step();
    check("t4_no_early_err", d_rvalid_o, 0);
    step();
    check("t4_d_rvalid", d_rvalid_o, 1);
    check("t4_d_rerr", d_rerr_o, 1);
    check("t4_d_rdata", d_rdata_o, 0);
    d_req_i = 1'b0;
    step();
    check("t4_drain_busy", busy_o, 1);
    check("t4_drain_no_grant", mem_arvalid_o, 0);
    step(); step();
    check("t4_drain_no_grant2", mem_arvalid_o, 0);
    exp_addr.push_back(32'h8000_4000);
    push_resp(1'b0, 32'hDEAD_BEEF, 1'b1);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_5555;
    step();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    check("t4_idle_after_late", busy_o, 0);
    check("t4_late_no_rvalid", i_rvalid_o, 0);
    step();
    check("t4_ifu_granted", mem_arvalid_o, 1);
    check("t4_ifu_owner", owner_o, 0);
    // Bus error passed through to the IFU.
    mem_txn(0, 1, 32'hDEAD_BEEF, 1'b1);
    check("t5_i_rerr", i_rerr_o, 1);
    i_req_i = 1'b0;
    step();

    // Reset while in WAIT, then a stray response.
    i_req_i = 1'b1; i_addr_i = 32'h8000_5000; mem_arready_i = 1'b1;
    exp_addr.push_back(32'h8000_5000);
    step();
    step();
    mem_arready_i = 1'b0;
    step();
    rst = 1'b1; i_req_i = 1'b0;
    #1;
    check("t6_rst_outs", {i_rvalid_o, i_rerr_o, i_rdata_o, d_rvalid_o, d_rerr_o,
                          mem_arvalid_o, busy_o}, 0);
    check("t6_rst_rdata_d", d_rdata_o, 0);
    check("t6_rst_araddr", mem_araddr_o, 0);
    check("t6_rst_owner", owner_o, 1);
    step(); step();
    rst = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h6666_6666;
    step();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    check("t6_stray_busy", busy_o, 0);
    check("t6_stray_rvalid", {i_rvalid_o, d_rvalid_o}, 0);
    i_req_i = 1'b1; i_addr_i = 32'h8000_6000;
    d_req_i = 1'b1; d_addr_i = 32'h8000_7000;
    exp_addr.push_back(32'h8000_6000); push_resp(1'b0, 32'hA5A5_0001, 1'b0);
    exp_addr.push_back(32'h8000_7000); push_resp(1'b1, 32'hA5A5_0002, 1'b0);
    step();
    check("t6_first_tie_ifu", owner_o, 0);
    mem_txn(0, 0, 32'hA5A5_0001, 1'b0);
    mem_txn(0, 0, 32'hA5A5_0002, 1'b0);
    i_req_i = 1'b0; d_req_i = 1'b0;
    step(); step(); step();

    check("end_resp_queue", exp_resp.size(), 0);
    check("end_addr_queue", exp_addr.size(), 0);
    check("end_busy", busy_o, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
